// File: rtl/fetch_pc_ctrl_if.sv
// Signal bundle between the fetch PC controller and its environment:
// redirect input, instruction memory handshake, decode handshake, PC view.
interface fetch_pc_ctrl_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic [31:0] pc;
   logic [31:0] npc;

   modport master (
      input  redirect_valid, redirect_pc,
      input  imem_gnt, imem_rvalid, imem_rdata,
      input  inst_ready,
      output imem_req, imem_addr,
      output inst_valid, inst, inst_pc,
      output pc, npc
   );

   modport slave (
      output redirect_valid, redirect_pc,
      output imem_gnt, imem_rvalid, imem_rdata,
      output inst_ready,
      input  imem_req, imem_addr,
      input  inst_valid, inst, inst_pc,
      input  pc, npc
   );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: owns the PC, issues one imem request at a time,
// holds the fetched instruction for decode and flushes on redirect.
module fetch_pc_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   fetch_pc_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_DISCARD,
      S_HOLD
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        inst_valid_q, inst_valid_d;

   logic [31:0] npc;
   logic [31:0] tgt;
   logic        redir;
   logic        unused_tgt_lsb;

   assign redir = bus.redirect_valid;
   assign tgt   = {bus.redirect_pc[31:2], 2'b00};
   assign npc   = pc_q + 32'd4;

   assign unused_tgt_lsb = ^bus.redirect_pc[1:0];

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;
      unique case (state_q)
         S_REQ: begin
            if (redir) begin
               pc_d = tgt;
            end else if (bus.imem_gnt) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redir) begin
               pc_d    = tgt;
               state_d = bus.imem_rvalid ? S_REQ : S_DISCARD;
            end else if (bus.imem_rvalid) begin
               inst_d       = bus.imem_rdata;
               inst_pc_d    = pc_q;
               pc_d         = npc;
               inst_valid_d = 1'b1;
               state_d      = S_HOLD;
            end
         end
         S_DISCARD: begin
            if (redir) begin
               pc_d = tgt;
            end
            // The stale response is swallowed here and never reaches decode
            if (bus.imem_rvalid) begin
               state_d = S_REQ;
            end
         end
         S_HOLD: begin
            if (redir) begin
               inst_valid_d = 1'b0;
               pc_d         = tgt;
               state_d      = S_REQ;
            end else if (bus.inst_ready) begin
               inst_valid_d = 1'b0;
               state_d      = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_REQ;
         pc_q         <= {RESET_PC[31:2], 2'b00};
         inst_q       <= 32'h0;
         inst_pc_q    <= 32'h0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   assign bus.imem_req   = (state_q == S_REQ) && !redir;
   assign bus.imem_addr  = pc_q;
   assign bus.inst_valid = inst_valid_q;
   assign bus.inst       = inst_q;
   assign bus.inst_pc    = inst_pc_q;
   assign bus.pc         = pc_q;
   assign bus.npc        = npc;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios plus a randomized run
// checked against a transaction-level model of fetch behaviour.
module tb_fetch_pc_ctrl;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   fetch_pc_ctrl_if bus ();
   fetch_pc_ctrl_if wb ();

   fetch_pc_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   fetch_pc_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic rv, input logic [31:0] rp,
                      input logic g, input logic r,
                      input logic [31:0] d, input logic rdy);
      bus.redirect_valid = rv;
      bus.redirect_pc    = rp;
      bus.imem_gnt       = g;
      bus.imem_rvalid    = r;
      bus.imem_rdata     = d;
      bus.inst_ready     = rdy;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0);
      #12;
      checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=%h", bus.pc, 32'h0); end
      checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%h exp=0", bus.inst_valid); end
      checks++; if (bus.inst !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", bus.inst); end
      checks++; if (bus.inst_pc !== 32'h0) begin failures++; $display("FAIL rst_inst_pc got=%h exp=0", bus.inst_pc); end
      checks++; if (wb.pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL rst_wrap_pc got=%h exp=fffffffc", wb.pc); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL rst_req got=%h exp=1", bus.imem_req); end
   endtask

   task automatic test_sequential();
      logic [31:0] a;
      for (int k = 0; k < 3; k++) begin
         a = 32'(k * 4);
         drv(0, 0, 1, 0, 0, 1);
         checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL seq_req got=%h exp=1", bus.imem_req); end
         checks++; if (bus.imem_addr !== a) begin failures++; $display("FAIL seq_addr got=%h exp=%h", bus.imem_addr, a); end
         checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL seq_v0 got=%h exp=0", bus.inst_valid); end
         tick();
         drv(0, 0, 0, 1, memw(a), 1);
         checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL seq_wait_req got=%h exp=0", bus.imem_req); end
         checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL seq_v1 got=%h exp=0", bus.inst_valid); end
         tick();
         drv(0, 0, 0, 0, 0, 1);
         checks++; if (bus.inst_valid !== 1'b1) begin failures++; $display("FAIL seq_v2 got=%h exp=1", bus.inst_valid); end
         checks++; if (bus.inst !== memw(a)) begin failures++; $display("FAIL seq_inst got=%h exp=%h", bus.inst, memw(a)); end
         checks++; if (bus.inst_pc !== a) begin failures++; $display("FAIL seq_inst_pc got=%h exp=%h", bus.inst_pc, a); end
         checks++; if (bus.pc !== a + 32'd4) begin failures++; $display("FAIL seq_pc got=%h exp=%h", bus.pc, a + 32'd4); end
         tick();
      end
   endtask

   task automatic test_stall();
      drv(0, 0, 1, 0, 0, 0);
      tick();
      drv(0, 0, 0, 1, memw(32'd12), 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         drv(0, 0, 0, 0, 0, 0);
         checks++; if (bus.inst_valid !== 1'b1) begin failures++; $display("FAIL stall_v got=%h exp=1", bus.inst_valid); end
         checks++; if (bus.inst !== memw(32'd12)) begin failures++; $display("FAIL stall_inst got=%h exp=%h", bus.inst, memw(32'd12)); end
         checks++; if (bus.inst_pc !== 32'd12) begin failures++; $display("FAIL stall_ipc got=%h exp=c", bus.inst_pc); end
         checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL stall_req got=%h exp=0", bus.imem_req); end
         checks++; if (bus.pc !== 32'd16) begin failures++; $display("FAIL stall_pc got=%h exp=10", bus.pc); end
         tick();
      end
      drv(0, 0, 0, 0, 0, 1);
      tick();
      drv(0, 0, 0, 0, 0, 0);
      checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL stall_rel_req got=%h exp=1", bus.imem_req); end
      checks++; if (bus.imem_addr !== 32'd16) begin failures++; $display("FAIL stall_rel_addr got=%h exp=10", bus.imem_addr); end
   endtask

   task automatic test_redirect_wait();
      drv(0, 0, 1, 0, 0, 0);
      tick();
      drv(1, 32'h100, 0, 0, 0, 0);
      checks++; if (bus.pc !== 32'd16) begin failures++; $display("FAIL rw_pc0 got=%h exp=10", bus.pc); end
      tick();
      drv(0, 0, 0, 0, 0, 0);
      checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rw_disc_req got=%h exp=0", bus.imem_req); end
      checks++; if (bus.pc !== 32'h100) begin failures++; $display("FAIL rw_pc1 got=%h exp=100", bus.pc); end
      tick();
      drv(0, 0, 0, 1, 32'hDEAD_BEEF, 0);
      tick();
      drv(0, 0, 0, 0, 0, 0);
      checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL rw_stale_v got=%h exp=0", bus.inst_valid); end
      checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL rw_req got=%h exp=1", bus.imem_req); end
      checks++; if (bus.imem_addr !== 32'h100) begin failures++; $display("FAIL rw_addr got=%h exp=100", bus.imem_addr); end
      drv(0, 0, 1, 0, 0, 0);
      tick();
      drv(0, 0, 0, 1, memw(32'h100), 0);
      tick();
      drv(0, 0, 0, 0, 0, 0);
      checks++; if (bus.inst !== memw(32'h100)) begin failures++; $display("FAIL rw_inst got=%h exp=%h", bus.inst, memw(32'h100)); end
      checks++; if (bus.inst_pc !== 32'h100) begin failures++; $display("FAIL rw_ipc got=%h exp=100", bus.inst_pc); end
   endtask

   task automatic test_redirect_hold();
      drv(1, 32'h203, 0, 0, 0, 1);
      checks++; if (bus.inst_valid !== 1'b1) begin failures++; $display("FAIL rh_v0 got=%h exp=1", bus.inst_valid); end
      tick();
      drv(0, 0, 0, 0, 0, 0);
      checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL rh_v1 got=%h exp=0", bus.inst_valid); end
      checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL rh_req got=%h exp=1", bus.imem_req); end
      checks++; if (bus.imem_addr !== 32'h200) begin failures++; $display("FAIL rh_addr got=%h exp=200", bus.imem_addr); end
      checks++; if (bus.npc !== 32'h204) begin failures++; $display("FAIL rh_npc got=%h exp=204", bus.npc); end
   endtask

   task automatic test_async_reset();
      drv(0, 0, 1, 0, 0, 0);
      tick();
      drv(0, 0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL ar_pc got=%h exp=0", bus.pc); end
      checks++; if (bus.inst !== 32'h0) begin failures++; $display("FAIL ar_inst got=%h exp=0", bus.inst); end
      checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL ar_v got=%h exp=0", bus.inst_valid); end
      checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL ar_req got=%h exp=1", bus.imem_req); end
      @(negedge clk);
      rst_n = 1'b1;
      drv(0, 0, 0, 1, 32'hCAFE_F00D, 0);
      tick();
      drv(0, 0, 0, 0, 0, 0);
      checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL ar_late_v got=%h exp=0", bus.inst_valid); end
      checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL ar_late_req got=%h exp=1", bus.imem_req); end
      checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL ar_late_addr got=%h exp=0", bus.imem_addr); end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc, out_addr, h_inst, h_pc, tgt, rd;
      logic        outst, live, held, redir, gnt, rdy, rvl, exp_req;
      int          wait_cnt, consumed;
      exp_pc = 32'h0; outst = 0; live = 0; held = 0;
      out_addr = 0; h_inst = 0; h_pc = 0; wait_cnt = 0; consumed = 0;
      for (int c = 0; c < 600; c++) begin
         redir = ($urandom_range(0, 5) == 0);
         tgt   = $urandom;
         gnt   = ($urandom_range(0, 9) < 6);
         rdy   = 1'($urandom_range(0, 1));
         rvl   = outst && (wait_cnt == 0);
         rd    = rvl ? memw(out_addr) : $urandom;
         drv(redir, tgt, gnt, rvl, rd, rdy);
         exp_req = !outst && !held && !redir;
         checks++; if (bus.imem_req !== exp_req) begin failures++; $display("FAIL rnd_req c=%0d got=%h exp=%h", c, bus.imem_req, exp_req); end
         checks++; if (bus.pc !== exp_pc) begin failures++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, bus.pc, exp_pc); end
         checks++; if (bus.npc !== exp_pc + 32'd4) begin failures++; $display("FAIL rnd_npc c=%0d got=%h exp=%h", c, bus.npc, exp_pc + 32'd4); end
         checks++; if (bus.inst_valid !== held) begin failures++; $display("FAIL rnd_valid c=%0d got=%h exp=%h", c, bus.inst_valid, held); end
         if (held) begin
            checks++; if (bus.inst !== h_inst) begin failures++; $display("FAIL rnd_inst c=%0d got=%h exp=%h", c, bus.inst, h_inst); end
            checks++; if (bus.inst_pc !== h_pc) begin failures++; $display("FAIL rnd_ipc c=%0d got=%h exp=%h", c, bus.inst_pc, h_pc); end
         end
         if (outst && !rvl) wait_cnt--;
         if (held && !redir && rdy) begin held = 0; consumed++; end
         if (redir) begin
            exp_pc = tgt & 32'hFFFF_FFFC;
            held   = 0;
            live   = 0;
         end
         if (rvl) begin
            outst = 0;
            if (live && !redir) begin
               held   = 1;
               h_pc   = out_addr;
               h_inst = memw(out_addr);
               exp_pc = out_addr + 32'd4;
            end
         end
         if (exp_req && gnt) begin
            outst    = 1;
            live     = 1;
            out_addr = exp_pc;
            wait_cnt = $urandom_range(0, 2);
         end
         tick();
      end
      checks++; if (consumed < 10) begin failures++; $display("FAIL rnd_progress got=%0d exp>=10", consumed); end
   endtask

   task automatic test_wrap();
      wb.imem_gnt = 1'b1;
      #1;
      checks++; if (wb.imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr0 got=%h exp=fffffffc", wb.imem_addr); end
      checks++; if (wb.npc !== 32'h0) begin failures++; $display("FAIL wrap_npc got=%h exp=0", wb.npc); end
      tick();
      wb.imem_gnt    = 1'b0;
      wb.imem_rvalid = 1'b1;
      wb.imem_rdata  = memw(32'hFFFF_FFFC);
      tick();
      wb.imem_rvalid = 1'b0;
      wb.inst_ready  = 1'b1;
      #1;
      checks++; if (wb.inst_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_ipc got=%h exp=fffffffc", wb.inst_pc); end
      checks++; if (wb.inst !== memw(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_inst got=%h exp=%h", wb.inst, memw(32'hFFFF_FFFC)); end
      tick();
      wb.inst_ready = 1'b0;
      #1;
      checks++; if (wb.imem_req !== 1'b1) begin failures++; $display("FAIL wrap_req got=%h exp=1", wb.imem_req); end
      checks++; if (wb.imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr1 got=%h exp=0", wb.imem_addr); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      wb.redirect_valid = 1'b0;
      wb.redirect_pc    = 32'h0;
      wb.imem_gnt       = 1'b0;
      wb.imem_rvalid    = 1'b0;
      wb.imem_rdata     = 32'h0;
      wb.inst_ready     = 1'b0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_wait();
      test_redirect_hold();
      test_async_reset();
      test_random();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-side PC controller that owns the architectural PC register and sequences instruction fetch around the PC select mux. Each cycle it picks between the sequential next PC (pc+4) and a redirect target (the ALU result for branches and jumps). It issues one request at a time to instruction memory over a request/grant/response handshake and presents fetched instructions to decode with a valid/ready handshake. It also discards stale responses and flushes held instructions when a redirect arrives mid-fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  taken branch/jump this cycle (PC select = ALU)
- redirect_pc  in  32  redirect target (ALU_C); bits [1:0] ignored, treated as 0
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, equals pc
- imem_gnt  in  1  memory accepted request this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  response instruction word
- inst_valid  out  1  instruction available to decode
- inst  out  32  held instruction
- inst_pc  out  32  address of held instruction
- inst_ready  in  1  decode accepts instruction
- pc  out  32  current fetch PC register
- npc  out  32  pc + 4, modulo 2^32

## Operation
- States: REQ, WAIT, DISCARD, HOLD. Reset state REQ.
- imem_req = (state==REQ) && !redirect_valid (combinational). imem_addr = pc.
- REQ:
  - redirect_valid: pc <= {redirect_pc[31:2],2'b00}; stay REQ.
  - else imem_gnt: go WAIT.
  - else stay REQ.
- WAIT:
  - rvalid && !redirect: inst <= rdata; inst_pc <= pc; pc <= npc; inst_valid <= 1; go HOLD.
  - redirect && rvalid: drop data; pc <= redirect target; go REQ.
  - redirect && !rvalid: pc <= redirect target; go DISCARD.
- DISCARD:
  - Next rvalid is dropped; then go REQ.
  - A further redirect updates pc again; stay DISCARD until the drop. If both occur in one cycle, pc takes the new target and the state goes to REQ.
- HOLD (inst_valid=1, inst/inst_pc stable):
  - redirect (with or without inst_ready): inst_valid <= 0; pc <= redirect target; go REQ. Redirect wins over handshake; the held instruction counts as flushed.
  - inst_ready && !redirect: inst_valid <= 0; go REQ.
- Only one memory transaction is outstanding. rvalid outside WAIT/DISCARD is a protocol error: ignore it, no state change.
- Arithmetic: npc = pc + 32'd4; 32'hFFFF_FFFC wraps to 32'h0000_0000.

## Timing
- Reset (async assert, sync release): pc=RESET_PC, state REQ, inst_valid=0, inst=0, inst_pc=0. imem_req rises combinationally in the first cycle after release.
- Reset mid-transaction aborts immediately. A late response after reset release arrives in REQ and is ignored.
- Best-case throughput: 1 instruction per 3 cycles. Cycle 1 is REQ+gnt, cycle 2 is WAIT+rvalid, cycle 3 is HOLD+ready.
- inst_valid asserts the cycle after rvalid is captured and holds until handshake or redirect.
- A redirect takes effect on pc at the next edge in every state. A request carrying the new pc is issued no earlier than the following cycle.
- Redirect-to-request path is combinational through imem_req; no other input-to-output combinational paths.

## Test plan
- Reset release, RESET_PC=0, memory gnt same cycle, rvalid next cycle, inst_ready=1 -> imem_addr sequence 0,4,8. inst_pc matches each. inst_valid pulses every 3rd cycle.
- Stall: hold inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable, imem_req=0, pc=prior+4. Release ready -> next req at new pc.
- Redirect in WAIT to 0x100 with rvalid two cycles later, data 0xDEADBEEF -> that data never appears on inst. Next imem_addr=0x100.
- Redirect in HOLD with inst_ready=1 same cycle, target 0x203 -> inst_valid drops without being counted as consumed. Next imem_addr=0x200.
- Wrap: RESET_PC=32'hFFFF_FFFC, one fetch -> inst_pc=FFFF_FFFC, next imem_addr=0.
- Async reset asserted in WAIT -> outputs return to reset values immediately. A response arriving after release is ignored. First req is at RESET_PC.
